dominant_color_detect: RTL and testbench

//  Upstream of the HEX colour display stage. Takes a stream of RGB pixels and splits it

---
 rtl/color_pkg.sv | 19 +
 rtl/pixel_classifier.sv | 54 +++++
 rtl/dominant_color_detect.sv | 146 ++++++++++++++
 tb/tb_dominant_color_detect.sv | 250 +++++++++++++++++++++++++
 4 files changed

// File: rtl/color_pkg.sv
// Shared types for the dominant colour detector.
// Colour codes match the HEX display stage encoding.
package color_pkg;

  typedef enum logic [1:0] {
    COLOR_RED   = 2'd0,
    COLOR_GREEN = 2'd1,
    COLOR_BLUE  = 2'd2,
    COLOR_NONE  = 2'd3
  } color_t;

  typedef enum logic [1:0] {
    S_IDLE,
    S_ACCUM,
    S_DRAIN,
    S_DECIDE
  } state_t;

endpackage

// File: rtl/pixel_classifier.sv
// Combinational per-pixel vote: a channel votes only if it beats
// both other channels by at least THRESH.
module pixel_classifier
  import color_pkg::*;
#(
  parameter int THRESH = 16
) (
  input  logic [7:0] r,
  input  logic [7:0] g,
  input  logic [7:0] b,
  output logic       vote_valid,
  output color_t     vote
);

  logic [8:0] r9, g9, b9;
  logic [8:0] rt, gt, bt;
  logic       r_win, g_win, b_win;

  assign r9 = {1'b0, r};
  assign g9 = {1'b0, g};
  assign b9 = {1'b0, b};

  assign rt = r9 + 9'(THRESH);
  assign gt = g9 + 9'(THRESH);
  assign bt = b9 + 9'(THRESH);

  assign r_win = (r9 >= gt) && (r9 >= bt);
  assign g_win = (g9 >= rt) && (g9 >= bt);
  assign b_win = (b9 >= rt) && (b9 >= gt);

  always_comb begin
    vote_valid = 1'b0;
    vote       = COLOR_NONE;
    unique case (1'b1)
      r_win: begin
        vote_valid = 1'b1;
        vote       = COLOR_RED;
      end
      g_win: begin
        vote_valid = 1'b1;
        vote       = COLOR_GREEN;
      end
      b_win: begin
        vote_valid = 1'b1;
        vote       = COLOR_BLUE;
      end
      default: begin
        vote_valid = 1'b0;
        vote       = COLOR_NONE;
      end
    endcase
  end

endmodule

// File: rtl/dominant_color_detect.sv
// Windowed majority vote of dominant RGB channel per pixel.
// Define DOMINANT_HYST_EN to require two equal decisions before main changes.
module dominant_color_detect
  import color_pkg::*;
#(
  parameter int WINDOW    = 64,
  parameter int THRESH    = 16,
  parameter int MIN_VOTES = 8
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       start,
  input  logic       pixel_valid,
  output logic       pixel_ready,
  input  logic [7:0] r,
  input  logic [7:0] g,
  input  logic [7:0] b,
  output logic [1:0] main,
  output logic       main_valid,
  output logic       busy
);

  localparam int CW = $clog2(WINDOW + 1);

  state_t          state;
  color_t          main_q;
  color_t          vote;
  color_t          vote_q;
  color_t          winner;
  color_t          raw_win;
  logic            vote_valid;
  logic            vote_vld_q;
  logic            accept;
  logic            last;
  logic [CW-1:0]   pix_cnt;
  logic [CW-1:0]   cnt_r, cnt_g, cnt_b;
  logic [CW-1:0]   top_cnt;
`ifdef DOMINANT_HYST_EN
  color_t          last_winner;
`endif

  pixel_classifier #(.THRESH(THRESH)) u_cls (
    .r          (r),
    .g          (g),
    .b          (b),
    .vote_valid (vote_valid),
    .vote       (vote)
  );

  assign pixel_ready = (state == S_ACCUM);
  assign busy        = (state != S_IDLE);
  assign main        = main_q;
  assign accept      = pixel_valid & pixel_ready;
  assign last        = accept && (pix_cnt == CW'(WINDOW - 1));

  // strict maximum; any tie for the top leaves raw_win at NONE
  always_comb begin
    raw_win = COLOR_NONE;
    top_cnt = '0;
    unique case (1'b1)
      (cnt_r > cnt_g) && (cnt_r > cnt_b): begin
        raw_win = COLOR_RED;
        top_cnt = cnt_r;
      end
      (cnt_g > cnt_r) && (cnt_g > cnt_b): begin
        raw_win = COLOR_GREEN;
        top_cnt = cnt_g;
      end
      (cnt_b > cnt_r) && (cnt_b > cnt_g): begin
        raw_win = COLOR_BLUE;
        top_cnt = cnt_b;
      end
      default: begin
        raw_win = COLOR_NONE;
        top_cnt = '0;
      end
    endcase
    winner = (32'(top_cnt) >= MIN_VOTES) ? raw_win : COLOR_NONE;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state       <= S_IDLE;
      main_q      <= COLOR_NONE;
      main_valid  <= 1'b0;
      vote_q      <= COLOR_NONE;
      vote_vld_q  <= 1'b0;
      pix_cnt     <= '0;
      cnt_r       <= '0;
      cnt_g       <= '0;
      cnt_b       <= '0;
`ifdef DOMINANT_HYST_EN
      last_winner <= COLOR_NONE;
`endif
    end else begin
      main_valid <= 1'b0;
      if (start) begin
        state      <= S_ACCUM;
        vote_vld_q <= 1'b0;
        pix_cnt    <= '0;
        cnt_r      <= '0;
        cnt_g      <= '0;
        cnt_b      <= '0;
      end else begin
        vote_vld_q <= accept & vote_valid;
        if (accept) begin
          vote_q <= vote;
        end
        if (vote_vld_q) begin
          unique case (vote_q)
            COLOR_RED:   cnt_r <= cnt_r + CW'(1);
            COLOR_GREEN: cnt_g <= cnt_g + CW'(1);
            COLOR_BLUE:  cnt_b <= cnt_b + CW'(1);
            default:     ;
          endcase
        end
        unique case (state)
          S_IDLE: ;
          S_ACCUM: begin
            if (accept) begin
              pix_cnt <= pix_cnt + CW'(1);
            end
            if (last) begin
              state <= S_DRAIN;
            end
          end
          S_DRAIN: state <= S_DECIDE;
          S_DECIDE: begin
            state      <= S_IDLE;
            main_valid <= 1'b1;
`ifdef DOMINANT_HYST_EN
            if (winner == last_winner) begin
              main_q <= winner;
            end
            last_winner <= winner;
`else
            main_q <= winner;
`endif
          end
          default: state <= S_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_dominant_color_detect.sv
// Scoreboard bench for dominant_color_detect (WINDOW=4, THRESH=16, MIN_VOTES=2).
// Expected colours are pushed when a window is driven and checked on main_valid.
module tb_dominant_color_detect;

  localparam int WIN  = 4;
  localparam int THR  = 16;
  localparam int MINV = 2;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       start;
  logic       pixel_valid;
  logic       pixel_ready;
  logic [7:0] r, g, b;
  logic [1:0] main;
  logic       main_valid;
  logic       busy;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int last_acc = 0;
  int m_main = 3;
  int m_last = 3;
  int q[$];

  localparam logic [23:0] RED = {8'd200, 8'd10, 8'd10};
  localparam logic [23:0] GRN = {8'd10, 8'd200, 8'd10};
  localparam logic [23:0] BLU = {8'd10, 8'd10, 8'd200};
  localparam logic [23:0] WEAK = {8'd100, 8'd90, 8'd90};

  dominant_color_detect #(
    .WINDOW(WIN), .THRESH(THR), .MIN_VOTES(MINV)
  ) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .start       (start),
    .pixel_valid (pixel_valid),
    .pixel_ready (pixel_ready),
    .r           (r),
    .g           (g),
    .b           (b),
    .main        (main),
    .main_valid  (main_valid),
    .busy        (busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // monitor: compare each decision against the scoreboard and its latency
  always @(negedge clk) begin
    if (reset_n && main_valid) begin
      if (q.size() == 0) begin
        chk("spurious_valid", 32'(main_valid), 0);
      end else begin
        chk("main", 32'(main), 32'(q.pop_front()));
        chk("latency", 32'(cyc - last_acc), 3);
      end
    end
    if (reset_n && pixel_valid && pixel_ready) last_acc = cyc;
  end

  function automatic int vote_of(input logic [23:0] p);
    int rr, gg, bb;
    rr = int'(p[23:16]);
    gg = int'(p[15:8]);
    bb = int'(p[7:0]);
    if (rr >= gg + THR && rr >= bb + THR) return 0;
    if (gg >= rr + THR && gg >= bb + THR) return 1;
    if (bb >= rr + THR && bb >= gg + THR) return 2;
    return 3;
  endfunction

  task automatic do_start();
    @(posedge clk); #1;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic px(input logic [23:0] p);
    int n = 0;
    {r, g, b} = p;
    pixel_valid = 1'b1;
    while (!pixel_ready && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    if (n == 20) chk("ready_timeout", 32'(pixel_ready), 1);
    @(posedge clk); #1;
    pixel_valid = 1'b0;
  endtask

  task automatic win4(input logic [23:0] p0, input logic [23:0] p1,
                      input logic [23:0] p2, input logic [23:0] p3,
                      input int gap);
    logic [23:0] ps[4];
    int c[4];
    int w;
    ps = '{p0, p1, p2, p3};
    c = '{0, 0, 0, 0};
    for (int i = 0; i < 4; i++) c[vote_of(ps[i])]++;
    w = 3;
    if (c[0] > c[1] && c[0] > c[2]) w = 0;
    else if (c[1] > c[0] && c[1] > c[2]) w = 1;
    else if (c[2] > c[0] && c[2] > c[1]) w = 2;
    if (w != 3 && c[w] < MINV) w = 3;
`ifdef DOMINANT_HYST_EN
    if (w == m_last) m_main = w;
    m_last = w;
`else
    m_main = w;
`endif
    q.push_back(m_main);
    for (int i = 0; i < 4; i++) begin
      px(ps[i]);
      if (gap > 0) repeat (gap) @(posedge clk);
      #1;
    end
  endtask

  task automatic drain();
    int n = 0;
    while ((q.size() != 0 || busy) && n < 30) begin
      @(posedge clk); #1;
      n++;
    end
    chk("queue_empty", 32'(q.size()), 0);
    chk("main_hold", 32'(main), 32'(m_main));
    chk("busy_idle", 32'(busy), 0);
  endtask

  initial begin
    reset_n = 1'b0;
    start = 1'b0;
    pixel_valid = 1'b0;
    {r, g, b} = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_main", 32'(main), 3);
    chk("rst_valid", 32'(main_valid), 0);
    chk("rst_ready", 32'(pixel_ready), 0);
    chk("rst_busy", 32'(busy), 0);
    reset_n = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("idle_ready", 32'(pixel_ready), 0);
    chk("idle_busy", 32'(busy), 0);

    do_start();
    chk("accum_busy", 32'(busy), 1);
    win4(RED, RED, RED, RED, 0);
    drain();

    do_start();
    win4(GRN, GRN, BLU, BLU, 0);
    drain();

    do_start();
    win4(WEAK, WEAK, WEAK, WEAK, 0);
    drain();
    do_start();
    win4(BLU, BLU, BLU, GRN, 0);
    drain();

    pixel_valid = 1'b1;
    {r, g, b} = RED;
    repeat (3) @(posedge clk);
    #1;
    chk("idle_ignore", 32'(pixel_ready), 0);
    pixel_valid = 1'b0;

    do_start();
    px(RED);
    px(RED);
    do_start();
    win4(GRN, GRN, GRN, GRN, 2);
    drain();

    // start coinciding with the last pixel discards the window
    do_start();
    px(RED);
    px(RED);
    px(RED);
    {r, g, b} = RED;
    pixel_valid = 1'b1;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    pixel_valid = 1'b0;
    chk("restart_ready", 32'(pixel_ready), 1);
    win4(BLU, BLU, BLU, BLU, 1);
    drain();

    do_start();
    win4(RED, GRN, RED, WEAK, 0);
    drain();

`ifdef DOMINANT_HYST_EN
    reset_n = 1'b0;
    #1;
    reset_n = 1'b1;
    m_main = 3;
    m_last = 3;
    do_start();
    win4(RED, RED, RED, RED, 0);
    drain();
    chk("hyst_1", 32'(main), 3);
    do_start();
    win4(GRN, GRN, GRN, GRN, 0);
    drain();
    chk("hyst_2", 32'(main), 3);
    do_start();
    win4(GRN, GRN, GRN, GRN, 0);
    drain();
    chk("hyst_3", 32'(main), 1);
`endif

    do_start();
    px(GRN);
    px(GRN);
    reset_n = 1'b0;
    #1;
    chk("midrst_main", 32'(main), 3);
    chk("midrst_ready", 32'(pixel_ready), 0);
    chk("midrst_busy", 32'(busy), 0);
    m_main = 3;
    m_last = 3;
    q.delete();
    @(posedge clk); #1;
    reset_n = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("post_rst_valid", 32'(main_valid), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
